// File: rtl/mmu_pkg.sv
// MMU shared definitions: translation level codes, page-size codes
// and the offset-width decode used by the TLB page-mask logic.
package mmu_pkg;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_ONE  = 2'd1,
    LVL_TWO  = 2'd2,
    LVL_RSVD = 2'd3
  } level_e;

  localparam logic [2:0] PS_MIN = 3'd1;
  localparam logic [2:0] PS_MAX = 3'd5;

  localparam logic [4:0] L2_BASE = 5'd11;
  localparam logic [4:0] L1_BASE = 5'd16;

  // Offset width in bits; zero means no valid page size.
  function automatic logic [4:0] off_width(
    input logic [1:0] level,
    input logic [2:0] ps
  );
    logic ok;
    ok = (ps >= PS_MIN) && (ps <= PS_MAX);
    off_width = 5'd0;
    unique case (1'b1)
      (level == LVL_TWO) && ok:
        off_width = L2_BASE + {2'b0, ps};
      (level == LVL_ONE) && ok:
        off_width = L1_BASE + {2'b0, ps};
      default: off_width = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mmu_tlb_pagemask.sv
// Page mask decode: level + page-size code to a 32-bit offset mask.
// Level 0, level 3 and out-of-range page sizes report invalid.
module mmu_tlb_pagemask
  import mmu_pkg::*;
(
  input  logic [1:0]  level,
  input  logic [2:0]  mmups,
  output logic [31:0] mask,
  output logic        invalid
);

  logic [4:0] width;

  assign width   = off_width(level, mmups);
  assign invalid = (width == 5'd0);
  assign mask    = invalid ? 32'd0
                 : ((32'd1 << width) - 32'd1);

endmodule

// File: rtl/mmu_tlb.sv
// Fully associative TLB with one-cycle registered lookup, lock/hold
// of the result, and fill with match/free/round-robin replacement.
module mmu_tlb
  import mmu_pkg::*;
#(
  parameter int P_ENTRY   = 8,
  parameter int P_FLAGS_W = 28
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iRESET_SYNC,
  input  logic                 iTLB_FLUSH,
  input  logic                 iLOOKUP_REQ,
  output logic                 oLOOKUP_BUSY,
  input  logic [1:0]           iLOOKUP_LEVEL,
  input  logic [2:0]           iLOOKUP_MMUPS,
  input  logic [31:0]          iLOOKUP_ADDR,
  output logic                 oLOOKUP_VALID,
  input  logic                 iLOOKUP_LOCK,
  output logic                 oLOOKUP_HIT,
  output logic [31:0]          oLOOKUP_PADDR,
  output logic [P_FLAGS_W-1:0] oLOOKUP_FLAGS,
  input  logic                 iFILL_REQ,
  input  logic [1:0]           iFILL_LEVEL,
  input  logic [2:0]           iFILL_MMUPS,
  input  logic [31:0]          iFILL_VADDR,
  input  logic [31:0]          iFILL_PADDR,
  input  logic [P_FLAGS_W-1:0] iFILL_FLAGS
);

  localparam int IW = $clog2(P_ENTRY);

  logic [P_ENTRY-1:0]   ent_valid;
  logic [1:0]           ent_level [P_ENTRY];
  logic [2:0]           ent_ps    [P_ENTRY];
  logic [31:0]          ent_vpn   [P_ENTRY];
  logic [31:0]          ent_ppn   [P_ENTRY];
  logic [P_FLAGS_W-1:0] ent_flags [P_ENTRY];
  logic [IW-1:0]        rr_ptr;

  logic [31:0] lk_mask;
  logic        lk_inv;
  logic        lk_hit;
  logic [IW-1:0] lk_idx;
  logic        accept;

  logic                 res_hit;
  logic [31:0]          res_paddr;
  logic [P_FLAGS_W-1:0] res_flags;

  logic [31:0]   fl_mask;
  logic          fl_inv;
  logic          fl_match;
  logic [IW-1:0] fl_match_idx;
  logic          fl_free;
  logic [IW-1:0] fl_free_idx;
  logic [IW-1:0] fl_idx;
  logic          fl_victim;
  logic          fill_ok;

  mmu_tlb_pagemask u_lk_mask (
    .level   (iLOOKUP_LEVEL),
    .mmups   (iLOOKUP_MMUPS),
    .mask    (lk_mask),
    .invalid (lk_inv)
  );

  mmu_tlb_pagemask u_fl_mask (
    .level   (iFILL_LEVEL),
    .mmups   (iFILL_MMUPS),
    .mask    (fl_mask),
    .invalid (fl_inv)
  );

  assign oLOOKUP_BUSY = oLOOKUP_VALID & iLOOKUP_LOCK;
  assign accept       = iLOOKUP_REQ & ~oLOOKUP_BUSY;

  // Associative search of the lookup address (first match wins).
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = 0; i < P_ENTRY; i++) begin
      if (!lk_hit && ent_valid[i]
          && ent_level[i] == iLOOKUP_LEVEL
          && ent_ps[i] == iLOOKUP_MMUPS
          && ent_vpn[i] == (iLOOKUP_ADDR & ~lk_mask)) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
    end
  end

  // Result formation; a concurrent flush forces a miss.
  always_comb begin
    res_hit   = 1'b0;
    res_paddr = 32'd0;
    res_flags = '0;
    if (iLOOKUP_LEVEL == LVL_NONE) begin
      res_hit   = 1'b1;
      res_paddr = iLOOKUP_ADDR;
    end else if (!lk_inv && lk_hit && !iTLB_FLUSH) begin
      res_hit   = 1'b1;
      res_paddr = (ent_ppn[lk_idx] & ~lk_mask)
                | (iLOOKUP_ADDR & lk_mask);
      res_flags = ent_flags[lk_idx];
    end
  end

  // Result register: hold while locked, load on accept.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oLOOKUP_VALID <= 1'b0;
      oLOOKUP_HIT   <= 1'b0;
      oLOOKUP_PADDR <= 32'd0;
      oLOOKUP_FLAGS <= '0;
    end else if (iRESET_SYNC) begin
      oLOOKUP_VALID <= 1'b0;
      oLOOKUP_HIT   <= 1'b0;
      oLOOKUP_PADDR <= 32'd0;
      oLOOKUP_FLAGS <= '0;
    end else if (oLOOKUP_BUSY) begin
      oLOOKUP_VALID <= 1'b1;
    end else if (accept) begin
      oLOOKUP_VALID <= 1'b1;
      oLOOKUP_HIT   <= res_hit;
      oLOOKUP_PADDR <= res_paddr;
      oLOOKUP_FLAGS <= res_flags;
    end else begin
      oLOOKUP_VALID <= 1'b0;
    end
  end

  // Fill slot choice: matching entry, else lowest free, else victim.
  always_comb begin
    fl_match     = 1'b0;
    fl_match_idx = '0;
    fl_free      = 1'b0;
    fl_free_idx  = '0;
    for (int i = 0; i < P_ENTRY; i++) begin
      if (!fl_match && ent_valid[i]
          && ent_level[i] == iFILL_LEVEL
          && ent_ps[i] == iFILL_MMUPS
          && ent_vpn[i] == (iFILL_VADDR & ~fl_mask)) begin
        fl_match     = 1'b1;
        fl_match_idx = IW'(i);
      end
      if (!fl_free && !ent_valid[i]) begin
        fl_free     = 1'b1;
        fl_free_idx = IW'(i);
      end
    end
    fl_victim = !fl_match && !fl_free;
    fl_idx    = fl_match ? fl_match_idx
              : fl_free  ? fl_free_idx
              : rr_ptr;
  end

  assign fill_ok = iFILL_REQ & ~fl_inv
                 & ~iTLB_FLUSH & ~iRESET_SYNC;

  // Valid bits and replacement pointer.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else if (iRESET_SYNC || iTLB_FLUSH) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else if (fill_ok) begin
      ent_valid[fl_idx] <= 1'b1;
      if (fl_victim) rr_ptr <= rr_ptr + IW'(1);
    end
  end

  // Entry payload; qualified by the valid bits, so no reset needed.
  always_ff @(posedge iCLOCK) begin
    if (fill_ok) begin
      ent_level[fl_idx] <= iFILL_LEVEL;
      ent_ps[fl_idx]    <= iFILL_MMUPS;
      ent_vpn[fl_idx]   <= iFILL_VADDR & ~fl_mask;
      ent_ppn[fl_idx]   <= iFILL_PADDR & ~fl_mask;
      ent_flags[fl_idx] <= iFILL_FLAGS;
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: translation, replacement, lock/flush
// interaction and reset behaviour with hand-computed expectations.
module tb_mmu_tlb;

  logic        clk;
  logic        rst_n;
  logic        rst_sync;
  logic        flush;
  logic        lk_req;
  logic        lk_busy;
  logic [1:0]  lk_level;
  logic [2:0]  lk_ps;
  logic [31:0] lk_addr;
  logic        lk_valid;
  logic        lk_lock;
  logic        lk_hit;
  logic [31:0] lk_paddr;
  logic [27:0] lk_flags;
  logic        fl_req;
  logic [1:0]  fl_level;
  logic [2:0]  fl_ps;
  logic [31:0] fl_vaddr;
  logic [31:0] fl_paddr;
  logic [27:0] fl_flags;

  int nvec;
  int nerr;

  mmu_tlb #(.P_ENTRY(8), .P_FLAGS_W(28)) dut (
    .iCLOCK        (clk),
    .inRESET       (rst_n),
    .iRESET_SYNC   (rst_sync),
    .iTLB_FLUSH    (flush),
    .iLOOKUP_REQ   (lk_req),
    .oLOOKUP_BUSY  (lk_busy),
    .iLOOKUP_LEVEL (lk_level),
    .iLOOKUP_MMUPS (lk_ps),
    .iLOOKUP_ADDR  (lk_addr),
    .oLOOKUP_VALID (lk_valid),
    .iLOOKUP_LOCK  (lk_lock),
    .oLOOKUP_HIT   (lk_hit),
    .oLOOKUP_PADDR (lk_paddr),
    .oLOOKUP_FLAGS (lk_flags),
    .iFILL_REQ     (fl_req),
    .iFILL_LEVEL   (fl_level),
    .iFILL_MMUPS   (fl_ps),
    .iFILL_VADDR   (fl_vaddr),
    .iFILL_PADDR   (fl_paddr),
    .iFILL_FLAGS   (fl_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  function automatic logic [31:0] va(input int i);
    return 32'h0001_0000 + (32'(i) << 12);
  endfunction

  function automatic logic [31:0] pa(input int i);
    return 32'h0010_0000 + (32'(i) << 12);
  endfunction

  task automatic set_lk(input logic [1:0] l,
                        input logic [2:0] p,
                        input logic [31:0] a);
    lk_req   = 1'b1;
    lk_level = l;
    lk_ps    = p;
    lk_addr  = a;
  endtask

  task automatic set_fl(input logic [1:0] l,
                        input logic [2:0] p,
                        input logic [31:0] v,
                        input logic [31:0] ph,
                        input logic [27:0] f);
    fl_req   = 1'b1;
    fl_level = l;
    fl_ps    = p;
    fl_vaddr = v;
    fl_paddr = ph;
    fl_flags = f;
  endtask

  task automatic lookup(input logic [1:0] l,
                        input logic [2:0] p,
                        input logic [31:0] a);
    set_lk(l, p, a);
    tick();
    lk_req = 1'b0;
  endtask

  task automatic fill(input logic [1:0] l,
                      input logic [2:0] p,
                      input logic [31:0] v,
                      input logic [31:0] ph,
                      input logic [27:0] f);
    set_fl(l, p, v, ph, f);
    tick();
    fl_req = 1'b0;
  endtask

  task automatic chk_res(input string tag,
                         input logic h,
                         input logic [31:0] ph,
                         input logic [31:0] f);
    chk({tag, ".valid"}, 32'(lk_valid), 32'd1);
    chk({tag, ".hit"}, 32'(lk_hit), 32'(h));
    chk({tag, ".paddr"}, lk_paddr, ph);
    chk({tag, ".flags"}, 32'(lk_flags), f);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(lk_valid), 32'd0);
    chk({tag, ".hit"}, 32'(lk_hit), 32'd0);
    chk({tag, ".paddr"}, lk_paddr, 32'd0);
    chk({tag, ".flags"}, 32'(lk_flags), 32'd0);
    chk({tag, ".busy"}, 32'(lk_busy), 32'd0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b1;
    rst_sync = 1'b0;
    flush = 1'b0;
    lk_req = 1'b0;
    lk_level = 2'd0;
    lk_ps = 3'd0;
    lk_addr = 32'd0;
    lk_lock = 1'b0;
    fl_req = 1'b0;
    fl_level = 2'd0;
    fl_ps = 3'd0;
    fl_vaddr = 32'd0;
    fl_paddr = 32'd0;
    fl_flags = 28'd0;
    #3 rst_n = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    lookup(2'd0, 3'd0, 32'h1234);
    chk_res("l0", 1'b1, 32'h1234, 32'h0);
    tick();
    chk("idle.valid", 32'(lk_valid), 32'd0);

    fill(2'd2, 3'd1, 32'h5000, 32'h8_0000, 28'h5);
    lookup(2'd2, 3'd1, 32'h5016);
    chk_res("4k.hit", 1'b1, 32'h8_0016, 32'h5);
    lookup(2'd2, 3'd1, 32'h6016);
    chk_res("4k.miss", 1'b0, 32'h0, 32'h0);

    fill(2'd1, 3'd5, 32'h20_0000, 32'h4000_0000, 28'hA);
    lookup(2'd1, 3'd4, 32'h3F_FFFC);
    chk_res("2m.ps4", 1'b0, 32'h0, 32'h0);
    lookup(2'd1, 3'd5, 32'h3F_FFFC);
    chk_res("2m.ps5", 1'b1, 32'h401F_FFFC, 32'hA);

    lookup(2'd3, 3'd1, 32'h5016);
    chk_res("lvl3", 1'b0, 32'h0, 32'h0);
    lookup(2'd2, 3'd0, 32'h5016);
    chk_res("badps", 1'b0, 32'h0, 32'h0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    lookup(2'd2, 3'd1, 32'h5016);
    chk_res("flushed", 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 9; i++)
      fill(2'd2, 3'd1, va(i), pa(i), 28'(i));
    lookup(2'd2, 3'd1, va(0) | 32'h234);
    chk_res("evict.p0", 1'b0, 32'h0, 32'h0);
    for (int i = 1; i < 9; i++) begin
      lookup(2'd2, 3'd1, va(i) | 32'h234);
      chk_res($sformatf("keep.p%0d", i), 1'b1,
              pa(i) | 32'h234, 32'(i));
    end
    fill(2'd2, 3'd1, va(9), pa(9), 28'd9);
    lookup(2'd2, 3'd1, va(1) | 32'h234);
    chk_res("evict.p1", 1'b0, 32'h0, 32'h0);
    lookup(2'd2, 3'd1, va(9) | 32'h234);
    chk_res("new.p9", 1'b1, pa(9) | 32'h234, 32'd9);

    fill(2'd2, 3'd1, va(2), pa(12), 28'hC);
    lookup(2'd2, 3'd1, va(2) | 32'h234);
    chk_res("ovw.p2", 1'b1, pa(12) | 32'h234, 32'hC);
    fill(2'd2, 3'd1, va(10), pa(10), 28'd10);
    lookup(2'd2, 3'd1, va(2) | 32'h234);
    chk_res("rr.p2", 1'b0, 32'h0, 32'h0);
    lookup(2'd2, 3'd1, va(3) | 32'h234);
    chk_res("rr.p3", 1'b1, pa(3) | 32'h234, 32'd3);

    set_lk(2'd2, 3'd1, va(11) | 32'h234);
    set_fl(2'd2, 3'd1, va(11), pa(11), 28'd11);
    tick();
    lk_req = 1'b0;
    fl_req = 1'b0;
    chk_res("same.pre", 1'b0, 32'h0, 32'h0);
    lookup(2'd2, 3'd1, va(11) | 32'h234);
    chk_res("same.post", 1'b1, pa(11) | 32'h234, 32'd11);

    lookup(2'd2, 3'd1, va(4) | 32'h234);
    chk_res("lock.base", 1'b1, pa(4) | 32'h234, 32'd4);
    lk_lock = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_lk(2'd2, 3'd1, va(5) | 32'h234);
      if (c == 1) begin
        flush = 1'b1;
        set_fl(2'd2, 3'd1, va(0), pa(0), 28'd0);
      end
      tick();
      flush = 1'b0;
      fl_req = 1'b0;
      chk_res($sformatf("lock.c%0d", c), 1'b1,
              pa(4) | 32'h234, 32'd4);
      chk($sformatf("lock.busy%0d", c),
          32'(lk_busy), 32'd1);
    end
    lk_req = 1'b0;
    lk_lock = 1'b0;
    #1;
    chk("unlock.busy", 32'(lk_busy), 32'd0);
    tick();
    chk("unlock.valid", 32'(lk_valid), 32'd0);
    lookup(2'd2, 3'd1, va(0) | 32'h234);
    chk_res("dropfill", 1'b0, 32'h0, 32'h0);
    lookup(2'd2, 3'd1, va(5) | 32'h234);
    chk_res("lockflush", 1'b0, 32'h0, 32'h0);

    fill(2'd2, 3'd1, va(6), pa(6), 28'd6);
    lookup(2'd2, 3'd1, va(6) | 32'h234);
    chk_res("pre.rst", 1'b1, pa(6) | 32'h234, 32'd6);
    lk_lock = 1'b1;
    tick();
    chk("held.busy", 32'(lk_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    tick();
    rst_n = 1'b1;
    lk_lock = 1'b0;
    lookup(2'd2, 3'd1, va(6) | 32'h234);
    chk_res("post.rst", 1'b0, 32'h0, 32'h0);

    fill(2'd2, 3'd1, va(7), pa(7), 28'd7);
    lookup(2'd2, 3'd1, va(7) | 32'h234);
    chk_res("pre.srst", 1'b1, pa(7) | 32'h234, 32'd7);
    rst_sync = 1'b1;
    tick();
    rst_sync = 1'b0;
    chk_zero("srst");
    lookup(2'd2, 3'd1, va(7) | 32'h234);
    chk_res("post.srst", 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 The block SHALL provide parameter P_ENTRY, default 8, number of TLB entries (power of two, 2..64).
REQ-002 The block SHALL provide parameter P_FLAGS_W, default 28, width of the per-page MMU flag field.
REQ-003 iCLOCK  in  1  sole clock; all state changes on rising edge.
REQ-004 inRESET  in  1  asynchronous active-low reset.
REQ-005 iRESET_SYNC  in  1  synchronous reset, active high, same effect as inRESET.
REQ-006 iTLB_FLUSH  in  1  invalidate all entries.
REQ-007 iLOOKUP_REQ  in  1  lookup request.
REQ-008 oLOOKUP_BUSY  out  1  lookup port cannot accept a request this cycle.
REQ-009 iLOOKUP_LEVEL  in  2  0=no translation, 1=1-level, 2=2-level, 3=reserved.
REQ-010 iLOOKUP_MMUPS  in  3  page-size code.
REQ-011 iLOOKUP_ADDR  in  32  logical address.
REQ-012 oLOOKUP_VALID  out  1  result valid.
REQ-013 iLOOKUP_LOCK  in  1  downstream stall of the result.
REQ-014 oLOOKUP_HIT  out  1  translation found.
REQ-015 oLOOKUP_PADDR  out  32  physical address.
REQ-016 oLOOKUP_FLAGS  out  P_FLAGS_W  flags of the hit entry.
REQ-017 iFILL_REQ  in  1  write one translation, supplied by the page walker.
REQ-018 iFILL_LEVEL  in  2; iFILL_MMUPS  in  3; iFILL_VADDR  in  32; iFILL_PADDR  in  32; iFILL_FLAGS  in  P_FLAGS_W.

Function
REQ-019 Offset width SHALL decode as follows: level 2, MMUPS 1..5 -> 12..16 bits (4K..64K); level 1, MMUPS 1..5 -> 17..21 bits (128K..2048K); any other MMUPS at level 1/2 is invalid.
REQ-020 Each entry SHALL hold valid, level, MMUPS, VPN (vaddr with offset bits zeroed), PPN (paddr with offset bits zeroed), and flags.
REQ-021 Entry match SHALL require valid, equal level, equal MMUPS, and equal non-offset address bits.
REQ-022 A lookup SHALL be accepted when iLOOKUP_REQ=1 and oLOOKUP_BUSY=0; the result SHALL appear on oLOOKUP_VALID exactly 1 cycle later.
REQ-023 On hit, oLOOKUP_PADDR SHALL equal PPN non-offset bits OR'd with the request offset bits, and oLOOKUP_FLAGS SHALL equal entry flags.
REQ-024 Level 0 SHALL return hit=1, PADDR=ADDR, FLAGS=0 without consulting entries.
REQ-025 Level 3 or invalid MMUPS SHALL return hit=0, PADDR=0, FLAGS=0.
REQ-026 While oLOOKUP_VALID=1 and iLOOKUP_LOCK=1, all result outputs SHALL hold and oLOOKUP_BUSY SHALL be 1; otherwise oLOOKUP_BUSY=0.
REQ-027 With no accepted request and no lock, oLOOKUP_VALID SHALL be 0 the next cycle.
REQ-028 A fill SHALL overwrite a matching entry if one exists; otherwise it SHALL take the lowest-index invalid entry; otherwise the entry at the round-robin pointer.
REQ-029 The round-robin pointer SHALL advance by 1 only on a victim replacement, wrapping from P_ENTRY-1 to 0.
REQ-030 A fill with invalid level/MMUPS or level 0 SHALL be ignored.
REQ-031 A lookup and fill in the same cycle SHALL see the pre-fill contents.
REQ-032 iTLB_FLUSH SHALL clear all valid bits in one cycle and reset the pointer to 0; a simultaneous fill is dropped; a simultaneous lookup returns the miss result.
REQ-033 Flush SHALL NOT disturb a held (locked) result.

Reset
REQ-034 On inRESET=0 or iRESET_SYNC=1: all entries invalid, pointer=0, oLOOKUP_VALID=0, oLOOKUP_HIT=0, oLOOKUP_PADDR=0, oLOOKUP_FLAGS=0, oLOOKUP_BUSY=0.
REQ-035 Reset mid-lock SHALL drop the held result; the first request after reset release SHALL be accepted normally.

Structure
REQ-036 Shared package mmu_pkg SHALL hold the level codes, the MMUPS codes, and the offset-width decode function.
REQ-037 Sub-module mmu_tlb_pagemask SHALL convert level+MMUPS into a 32-bit offset mask plus an invalid flag; it SHALL be instantiated once for lookup and once for fill.

Verification
REQ-038 Level 0 lookup 0x1234 -> next cycle VALID=1, HIT=1, PADDR=0x1234.
REQ-039 Fill L2/4K VADDR=0x00005000, PADDR=0x00080000, FLAGS=0x5; then lookup 0x00005016 -> HIT=1, PADDR=0x00080016, FLAGS=0x5; lookup 0x00006016 -> HIT=0.
REQ-040 Fill L1/2048K VADDR=0x00200000, PADDR=0x40000000; lookup with MMUPS=4 -> miss; lookup with MMUPS=5 at 0x003FFFFC -> PADDR=0x401FFFFC.
REQ-041 P_ENTRY=8: fill 9 distinct 4K pages -> page 0 evicted (miss), pages 1..8 hit; a 10th fill evicts page 1.
REQ-042 Hold iLOOKUP_LOCK for 3 cycles after a hit -> outputs stable and BUSY=1; concurrent requests ignored; flush plus fill in the same cycle -> subsequent lookup misses.
REQ-043 Assert inRESET during a locked result -> all outputs 0; previously filled page misses after reset.
